sync_queue: RTL and testbench



---
 rtl/sync_queue.sv | 94 +++++++++
 tb/tb_sync_queue.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sync_queue.sv
// Circular show-ahead FIFO with optional preloaded index list,
// usable as a physical-register free list or an inter-stage queue.
module sync_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int SHOW_DEBUG = 0,
    parameter int INIT_CODE  = 0,
    parameter     QUEUE_NAME = "QUEUE"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pushReq_IN,
    input  logic [DATA_WIDTH-1:0] data_IN,
    output logic                  fullFlag_OUT,
    input  logic                  popReq_IN,
    output logic [DATA_WIDTH-1:0] data_OUT,
    output logic                  emptyFlag_OUT,
    input  logic                  flush_IN
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic [ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  push_ok, pop_ok;

    assign fullFlag_OUT  = (cnt_q == (ADDR_WIDTH+1)'(DEPTH));
    assign emptyFlag_OUT = (cnt_q == '0);
    assign push_ok       = pushReq_IN && !fullFlag_OUT;
    assign pop_ok        = popReq_IN && !emptyFlag_OUT;
    assign data_OUT      = emptyFlag_OUT ? '0 : mem_q[head_q];

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (push_ok) tail_d = tail_q + 1'b1;
        if (pop_ok)  head_d = head_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (flush_IN) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (INIT_CODE == 1) begin
                // Entry 0 stays out of the list: it names the hardwired register.
                head_q <= ADDR_WIDTH'(1);
                tail_q <= '0;
                cnt_q  <= (ADDR_WIDTH+1)'(DEPTH - 1);
            end else begin
                head_q <= '0;
                tail_q <= '0;
                cnt_q  <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (INIT_CODE == 1) begin
                for (int i = 0; i < DEPTH; i++)
                    mem_q[i] <= DATA_WIDTH'(i);
            end
        end else if (push_ok && !flush_IN) begin
            mem_q[tail_q] <= data_IN;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (SHOW_DEBUG != 0 && !reset && !flush_IN) begin
            if (push_ok)
                $display("%s push %h count=%0d", QUEUE_NAME, data_IN, cnt_d);
            if (pop_ok)
                $display("%s pop %h count=%0d", QUEUE_NAME, data_OUT, cnt_d);
        end
    end
`endif

endmodule

// File: tb/tb_sync_queue.sv
// Directed bench for sync_queue: an empty-reset 4-deep queue and
// an 8-deep preloaded free list, checked against hand-computed values.
module tb_sync_queue;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_push, a_pop, a_fl, a_full, a_empty;
    logic [7:0] a_din, a_dout;
    logic       b_rst, b_push, b_pop, b_fl, b_full, b_empty;
    logic [7:0] b_din, b_dout;

    int total = 0;
    int bad   = 0;

    sync_queue #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .INIT_CODE(0), .QUEUE_NAME("QA")
    ) u_a (
        .clk(clk), .reset(a_rst),
        .pushReq_IN(a_push), .data_IN(a_din), .fullFlag_OUT(a_full),
        .popReq_IN(a_pop), .data_OUT(a_dout), .emptyFlag_OUT(a_empty),
        .flush_IN(a_fl)
    );

    sync_queue #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .INIT_CODE(1), .QUEUE_NAME("QB")
    ) u_b (
        .clk(clk), .reset(b_rst),
        .pushReq_IN(b_push), .data_IN(b_din), .fullFlag_OUT(b_full),
        .popReq_IN(b_pop), .data_OUT(b_dout), .emptyFlag_OUT(b_empty),
        .flush_IN(b_fl)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_cyc(input logic rs, input logic fl, input logic ps,
                         input logic pp, input logic [7:0] d);
        a_rst = rs; a_fl = fl; a_push = ps; a_pop = pp; a_din = d;
        tick();
        a_rst = 0; a_fl = 0; a_push = 0; a_pop = 0; a_din = 0;
    endtask

    task automatic b_cyc(input logic rs, input logic fl, input logic ps,
                         input logic pp, input logic [7:0] d);
        b_rst = rs; b_fl = fl; b_push = ps; b_pop = pp; b_din = d;
        tick();
        b_rst = 0; b_fl = 0; b_push = 0; b_pop = 0; b_din = 0;
    endtask

    task automatic a_flags(input string tag, input logic e, input logic f,
                           input logic [7:0] d);
        check({tag, ".empty"}, 32'(a_empty), 32'(e));
        check({tag, ".full"}, 32'(a_full), 32'(f));
        check({tag, ".data"}, 32'(a_dout), 32'(d));
    endtask

    initial begin
        a_rst = 0; a_fl = 0; a_push = 0; a_pop = 0; a_din = 0;
        b_rst = 0; b_fl = 0; b_push = 0; b_pop = 0; b_din = 0;

        // Queue A: empty reset, depth 4
        a_cyc(1, 0, 0, 0, 8'h00);
        a_flags("a_reset", 1, 0, 8'h00);
        a_cyc(0, 0, 1, 0, 8'hA1);
        a_flags("a_push1", 0, 0, 8'hA1);
        a_cyc(0, 0, 0, 1, 8'h00);
        a_flags("a_pop1", 1, 0, 8'h00);

        a_cyc(0, 0, 1, 0, 8'h11);
        a_cyc(0, 0, 1, 0, 8'h22);
        a_cyc(0, 0, 1, 0, 8'h33);
        check("a_fill3.full", 32'(a_full), 32'd0);
        a_cyc(0, 0, 1, 0, 8'h44);
        a_flags("a_fill4", 0, 1, 8'h11);
        a_cyc(0, 0, 1, 0, 8'h55);
        a_flags("a_over", 0, 1, 8'h11);
        for (int i = 0; i < 4; i++) begin
            check("a_drain.data", 32'(a_dout), 32'(8'h11 * (i + 1)));
            a_cyc(0, 0, 0, 1, 8'h00);
        end
        a_flags("a_drained", 1, 0, 8'h00);
        a_cyc(0, 0, 0, 1, 8'h00);
        a_flags("a_underflow", 1, 0, 8'h00);

        // push+pop at count 2
        a_cyc(0, 0, 1, 0, 8'h81);
        a_cyc(0, 0, 1, 0, 8'h82);
        a_cyc(0, 0, 1, 1, 8'h77);
        a_flags("a_pp2", 0, 0, 8'h82);
        a_cyc(0, 0, 0, 1, 8'h00);
        a_flags("a_pp2b", 0, 0, 8'h77);
        a_cyc(0, 0, 0, 1, 8'h00);
        a_flags("a_pp2c", 1, 0, 8'h00);

        // push+pop at full: only the pop is taken
        a_cyc(0, 0, 1, 0, 8'h61);
        a_cyc(0, 0, 1, 0, 8'h62);
        a_cyc(0, 0, 1, 0, 8'h63);
        a_cyc(0, 0, 1, 0, 8'h64);
        a_cyc(0, 0, 1, 1, 8'h99);
        a_flags("a_ppfull", 0, 0, 8'h62);
        a_cyc(0, 0, 0, 1, 8'h00);
        check("a_ppf1.data", 32'(a_dout), 32'h63);
        a_cyc(0, 0, 0, 1, 8'h00);
        check("a_ppf2.data", 32'(a_dout), 32'h64);
        a_cyc(0, 0, 0, 1, 8'h00);
        a_flags("a_ppf3", 1, 0, 8'h00);

        // push+pop at empty: only the push is taken
        a_cyc(0, 0, 1, 1, 8'h5A);
        a_flags("a_ppempty", 0, 0, 8'h5A);
        a_cyc(0, 0, 0, 1, 8'h00);
        a_flags("a_ppempty2", 1, 0, 8'h00);

        // wrap-around
        for (int i = 0; i < 10; i++) begin
            a_cyc(0, 0, 1, 0, 8'(i));
            a_flags("a_wrap_push", 0, 0, 8'(i));
            a_cyc(0, 0, 0, 1, 8'h00);
            a_flags("a_wrap_pop", 1, 0, 8'h00);
        end

        // flush with a same-cycle push
        a_cyc(0, 0, 1, 0, 8'h01);
        a_cyc(0, 0, 1, 0, 8'h02);
        a_cyc(0, 0, 1, 0, 8'h03);
        a_cyc(0, 1, 1, 0, 8'h04);
        a_flags("a_flush", 1, 0, 8'h00);
        a_cyc(0, 0, 1, 0, 8'h07);
        a_flags("a_postflush", 0, 0, 8'h07);

        // reset with a same-cycle push
        a_cyc(0, 0, 1, 0, 8'h08);
        a_cyc(1, 0, 1, 0, 8'h09);
        a_flags("a_rstpush", 1, 0, 8'h00);

        // Queue B: preloaded free list, depth 8
        b_cyc(1, 0, 0, 0, 8'h00);
        check("b_reset.data", 32'(b_dout), 32'h1);
        check("b_reset.empty", 32'(b_empty), 32'd0);
        check("b_reset.full", 32'(b_full), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            check("b_pop.data", 32'(b_dout), 32'(i));
            check("b_pop.empty", 32'(b_empty), 32'd0);
            b_cyc(0, 0, 0, 1, 8'h00);
        end
        check("b_drained.empty", 32'(b_empty), 32'd1);
        check("b_drained.data", 32'(b_dout), 32'h0);
        b_cyc(0, 0, 1, 0, 8'h05);
        check("b_push5.data", 32'(b_dout), 32'h5);
        check("b_push5.empty", 32'(b_empty), 32'd0);

        // preloaded list plus one push fills it
        b_cyc(1, 0, 0, 0, 8'h00);
        b_cyc(0, 0, 1, 0, 8'h20);
        check("b_fill.full", 32'(b_full), 32'd1);
        check("b_fill.data", 32'(b_dout), 32'h1);
        b_cyc(0, 1, 0, 0, 8'h00);
        check("b_flush.empty", 32'(b_empty), 32'd1);
        check("b_flush.data", 32'(b_dout), 32'h0);
        check("b_flush.full", 32'(b_full), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
